// File: rtl/multi_pattern_ids.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_pattern_ids : pass-through packet stream with per-channel masked
//                     7-byte pattern matching and saturating hit counters
// Revision 1.0
// ---------------------------------------------------------------------------
module multi_pattern_ids #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int NUM_PATTERNS    = 4,
  parameter int HDR_WORDS       = 3,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic [64*NUM_PATTERNS-1:0]   patterns,
  input  logic [NUM_PATTERNS-1:0]      chan_en,
  input  logic                         clear_counters,
  output logic [32*NUM_PATTERNS-1:0]   match_counts,
  output logic [NUM_PATTERNS-1:0]      match_vec,
  output logic                         match_valid
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_LVL        = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] NEARLY_FULL_LVL = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH - 1);
  localparam logic [2:0]               HDR_LAST        = 3'(HDR_WORDS);

  typedef enum logic [1:0] {
    START   = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Input FIFO
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic                       push, pop;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [CTRL_WIDTH-1:0]      head_ctrl;

  assign push   = in_wr && (count_q != FULL_LVL);
  assign pop    = (count_q != '0) && out_rdy;
  assign in_rdy = (count_q < NEARLY_FULL_LVL);
  assign {head_ctrl, head_data} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_ctrl, in_data};
  end

  // Parser / matcher state
  state_e                    state_q, state_d;
  logic [2:0]                hdr_cnt_q, hdr_cnt_d;
  logic [DATA_WIDTH-1:0]     prev_q, prev_d;
  logic                      prev_valid_q, prev_valid_d;
  logic [NUM_PATTERNS-1:0]   sticky_q, sticky_d;
  logic [NUM_PATTERNS-1:0]   match_vec_q, match_vec_d;
  logic                      match_valid_q, match_valid_d;
  logic                      out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]     out_ctrl_q, out_ctrl_d;
  logic [NUM_PATTERNS-1:0]   hit;
  logic [2*DATA_WIDTH-1:0]   window;

  assign window = {prev_q, head_data};

  generate
    for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_chan
      logic [63:0] pat;
      logic        unused_pat_bit7;
      logic        win_hit;
      logic [31:0] cnt_q, cnt_d;

      assign pat             = patterns[64*i +: 64];
      assign unused_pat_bit7 = pat[7];

      // Offsets 2..7 reach back into prev_q, so they need a payload predecessor.
      always_comb begin
        win_hit = 1'b0;
        for (int off = 2; off < 10; off++) begin
          logic ok;
          ok = (off >= 8) || prev_valid_q;
          for (int j = 0; j < 7; j++) begin
            if (pat[6-j] && (window[127 - 8*(off+j) -: 8] != pat[63 - 8*j -: 8])) ok = 1'b0;
          end
          if (ok) win_hit = 1'b1;
        end
      end

      assign hit[i] = win_hit && (pat[6:0] != 7'd0) && chan_en[i];

      always_comb begin
        cnt_d = cnt_q;
        if (clear_counters) cnt_d = '0;
        else if (match_valid_q && match_vec_q[i] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign match_counts[32*i +: 32] = cnt_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    sticky_d      = sticky_q;
    match_vec_d   = match_vec_q;
    match_valid_d = 1'b0;
    out_wr_d      = pop;
    out_data_d    = pop ? head_data : out_data_q;
    out_ctrl_d    = pop ? head_ctrl : out_ctrl_q;
    if (pop) begin
      unique case (state_q)
        START: begin
          if (head_ctrl != '0) begin
            state_d      = HEADER;
            hdr_cnt_d    = '0;
            sticky_d     = '0;
            prev_valid_d = 1'b0;
          end
        end
        HEADER: begin
          if (head_ctrl == '0) begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            if (hdr_cnt_d == HDR_LAST) state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          sticky_d = sticky_q | hit;
          if (head_ctrl == '0) begin
            prev_d       = head_data;
            prev_valid_d = 1'b1;
          end else begin
            state_d       = START;
            prev_valid_d  = 1'b0;
            match_valid_d = 1'b1;
            match_vec_d   = sticky_q | hit;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= START;
      hdr_cnt_q     <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      sticky_q      <= '0;
      match_vec_q   <= '0;
      match_valid_q <= 1'b0;
      out_wr_q      <= 1'b0;
      out_data_q    <= '0;
      out_ctrl_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      sticky_q      <= sticky_d;
      match_vec_q   <= match_vec_d;
      match_valid_q <= match_valid_d;
      out_wr_q      <= out_wr_d;
      out_data_q    <= out_data_d;
      out_ctrl_q    <= out_ctrl_d;
    end
  end

  assign out_wr      = out_wr_q;
  assign out_data    = out_data_q;
  assign out_ctrl    = out_ctrl_q;
  assign match_vec   = match_vec_q;
  assign match_valid = match_valid_q;

endmodule
`default_nettype wire

// File: doc/multi_pattern_ids.md
MULTI_PATTERN_IDS -- requirements
Module: multi_pattern_ids

Interface
REQ-001 Parameter DATA_WIDTH, default 64: datapath width in bits; fixed at 64 for this revision.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: control width in bits.
REQ-003 Parameter NUM_PATTERNS, default 4: number of independent pattern channels, range 1..8.
REQ-004 Parameter HDR_WORDS, default 3: number of ctrl==0 header words skipped before the payload, range 1..7.
REQ-005 Parameter FIFO_DEPTH_BITS, default 2: log2 of the input FIFO depth.
REQ-006 clk  in  1  clock; all logic is rising-edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 in_data/in_ctrl/in_wr  in  64/8/1  upstream word, control and write strobe.
REQ-009 in_rdy  out  1  high when the input FIFO is not nearly full.
REQ-010 out_data/out_ctrl/out_wr  out  64/8/1  downstream word, control and write strobe.
REQ-011 out_rdy  in  1  downstream can accept a word.
REQ-012 patterns  in  64*NUM_PATTERNS  per channel: bits [63:8] are 7 pattern bytes, with byte 0 at [63:56]; bits [6:0] are the byte mask, bit 6 ↔ byte 0, and 1 means compare.
REQ-013 chan_en  in  NUM_PATTERNS  per-channel enable.
REQ-014 clear_counters  in  1  level; zeroes all counters.
REQ-015 match_counts  out  32*NUM_PATTERNS  per-channel matched-packet counters.
REQ-016 match_vec/match_valid  out  NUM_PATTERNS/1  per-packet result vector and its one-cycle strobe.

Function
REQ-017 The block SHALL be a pass-through: every accepted word is emitted unmodified and in order, and no packet is dropped.
REQ-018 A word SHALL transfer from the FIFO when the FIFO is non-empty and out_rdy=1; out_wr/out_data/out_ctrl SHALL be registered, giving exactly 1 cycle from FIFO read to out_wr.
REQ-019 When out_rdy=0, the FIFO SHALL be held, out_wr SHALL be 0 on the following cycle, and the parser/matcher state SHALL be frozen.
REQ-020 The parser FSM SHALL have states START, HEADER and PAYLOAD, and SHALL advance only on transferred words.
REQ-021 START→HEADER SHALL occur on a word with ctrl≠0; hdr_cnt is cleared.
REQ-022 In HEADER, each ctrl==0 word SHALL increment hdr_cnt (3-bit), and the FSM SHALL enter PAYLOAD when hdr_cnt reaches HDR_WORDS; ctrl≠0 words in HEADER SHALL be ignored.
REQ-023 In PAYLOAD, ctrl==0 words SHALL be matched; a ctrl≠0 word is the last word, SHALL be matched, and SHALL return the FSM to START.
REQ-024 Matching SHALL form a 16-byte window {prev_word, cur_word}; channel i SHALL hit when any 7-byte window starting at byte offset 2..9 equals the pattern on all masked bytes.
REQ-025 Windows straddling into prev_word SHALL be valid only when prev_word is a payload word of the same packet; the first payload word SHALL test offsets 8..9 only.
REQ-026 A mask of 0 SHALL never hit, and chan_en[i]=0 SHALL force channel i not to hit.
REQ-027 Each channel SHALL have a sticky hit flag, set on any hit and cleared on START→HEADER.
REQ-028 One cycle after the last word transfers, match_valid SHALL be 1 for exactly one cycle, with match_vec equal to the sticky flags including the last word's hit.
REQ-029 At match_valid, each set match_vec bit SHALL increment its counter, saturating at 0xFFFFFFFF.
REQ-030 If clear_counters=1 coincides with an increment, the clear SHALL win and the result SHALL be 0.
REQ-031 A packet that ends in HEADER or START (too short) SHALL produce no match_valid.
REQ-032 Pattern and mask changes mid-packet SHALL take effect on the next compared word.

Reset
REQ-033 On reset, the FSM SHALL go to START, the FIFO SHALL be emptied, and hdr_cnt, sticky flags and prev-valid SHALL be set to 0.
REQ-034 On reset, out_wr, out_data, out_ctrl, match_valid, match_vec and match_counts SHALL all be 0, and in_rdy SHALL be 1 on the cycle after reset deasserts.
REQ-035 Reset asserted mid-packet SHALL discard the partial packet and produce no match_valid for it.

Verification
REQ-036 Ch0 pattern "ABCDEFG", mask 0x7F, in payload word 2 at offset 0, out_rdy=1 -> match_vec=0001, match_counts[0]=1, output identical to input.
REQ-037 Pattern split across payload words 1/2 (4+3 bytes) -> hit; same bytes split across the last header word and the first payload word -> no hit.
REQ-038 Mask 0x41 on ch1 ('A'…'G' only) with four channels enabled and ch2 chan_en=0 -> ch1 hits on "AxxxxxG", ch2 never counts.
REQ-039 out_rdy toggled 1/0 every cycle over a 10-word packet -> no word lost or duplicated; match_valid fires exactly once.
REQ-040 Counter preset to 0xFFFFFFFF plus a hit -> it stays 0xFFFFFFFF; clear_counters on the match_valid cycle -> 0.
REQ-041 Reset asserted at payload word 3 then a clean packet -> exactly one match_valid, for the clean packet only.
